// File: rtl/simplecpu_pkg.sv
// Shared definitions for simplecpu and its UART program loader: bus widths,
// opcode map, loader frame header and FSM state encodings.
package simplecpu_pkg;

   localparam int CPU_ADDR_W = 4;
   localparam int CPU_DATA_W = 8;

   localparam logic [7:0] LOAD_HDR = 8'hA5;

   // Upper nibble of an instruction word; lower nibble is the operand address.
   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef enum logic [2:0] {
      LD_IDLE,
      LD_COUNT,
      LD_DATA,
      LD_CSUM,
      LD_DONE,
      LD_ERROR
   } loader_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/simplecpu_uart_rx.sv
// 8N1 UART receiver: synchronises the line, rejects false starts and reports
// each byte or framing error with a one-cycle pulse.
module simplecpu_uart_rx
   import simplecpu_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_BIT  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);

   rx_state_t     state, state_n;
   logic          rx_meta, rx_sync, rx_prev;
   logic [CW-1:0] tick, tick_n;
   logic [2:0]    bit_idx, bit_idx_n;
   logic [7:0]    shift, shift_n;
   logic          byte_valid_n, frame_err_n;

   assign byte_data = shift;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta    <= 1'b1;
         rx_sync    <= 1'b1;
         rx_prev    <= 1'b1;
         state      <= RX_IDLE;
         tick       <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_meta    <= rx;
         rx_sync    <= rx_meta;
         rx_prev    <= rx_sync;
         state      <= state_n;
         tick       <= tick_n;
         bit_idx    <= bit_idx_n;
         shift      <= shift_n;
         byte_valid <= byte_valid_n;
         frame_err  <= frame_err_n;
      end
   end

   // Start is re-checked at half a bit, so every later sample lands mid-bit.
   always_comb begin
      state_n      = state;
      tick_n       = tick + 1'b1;
      bit_idx_n    = bit_idx;
      shift_n      = shift;
      byte_valid_n = 1'b0;
      frame_err_n  = 1'b0;
      case (state)
         RX_IDLE: begin
            tick_n    = '0;
            bit_idx_n = '0;
            if (rx_prev && !rx_sync)
               state_n = RX_START;
         end
         RX_START: begin
            if (tick == HALF_BIT) begin
               tick_n  = '0;
               state_n = rx_sync ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (tick == LAST_TICK) begin
               tick_n    = '0;
               shift_n   = {rx_sync, shift[7:1]};
               bit_idx_n = bit_idx + 3'd1;
               if (bit_idx == 3'd7)
                  state_n = RX_STOP;
            end
         end
         RX_STOP: begin
            if (tick == LAST_TICK) begin
               tick_n       = '0;
               state_n      = RX_IDLE;
               byte_valid_n = rx_sync;
               frame_err_n  = !rx_sync;
            end
         end
         default: state_n = RX_IDLE;
      endcase
   end

endmodule

// File: rtl/simplecpu_uart_loader.sv
// Loads a checksummed program frame from the UART into simplecpu RAM and
// keeps the CPU in reset until a complete, verified image has been written.
module simplecpu_uart_loader
   import simplecpu_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int RAM_DEPTH    = 16,
   parameter int TIMEOUT_CLKS = 640
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  uart_rx,
   output logic                  load_ram,
   output logic [CPU_ADDR_W-1:0] load_addr,
   output logic [CPU_DATA_W-1:0] load_data,
   output logic                  cpu_run,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int TW = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CLKS - 1);
   localparam logic [7:0]    MAX_COUNT    = 8'(RAM_DEPTH);

   loader_state_t         state, state_n;
   logic [7:0]            remaining, remaining_n;
   logic [7:0]            sum, sum_n;
   logic [CPU_ADDR_W-1:0] addr, addr_n;
   logic [TW-1:0]         idle_cnt, idle_cnt_n;
   logic                  load_ram_n;
   logic [CPU_ADDR_W-1:0] load_addr_n;
   logic [CPU_DATA_W-1:0] load_data_n;
   logic                  byte_valid, frame_err, in_frame;
   logic [7:0]            byte_data;

   simplecpu_uart_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .clk       (clk),
      .reset     (reset),
      .rx        (uart_rx),
      .byte_valid(byte_valid),
      .byte_data (byte_data),
      .frame_err (frame_err)
   );

   assign in_frame = (state == LD_COUNT) || (state == LD_DATA) || (state == LD_CSUM);
   assign busy     = in_frame;
   assign done     = (state == LD_DONE);
   assign cpu_run  = (state == LD_DONE);
   assign error    = (state == LD_ERROR);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= LD_IDLE;
         remaining <= '0;
         sum       <= '0;
         addr      <= '0;
         idle_cnt  <= '0;
         load_ram  <= 1'b0;
         load_addr <= '0;
         load_data <= '0;
      end else begin
         state     <= state_n;
         remaining <= remaining_n;
         sum       <= sum_n;
         addr      <= addr_n;
         idle_cnt  <= idle_cnt_n;
         load_ram  <= load_ram_n;
         load_addr <= load_addr_n;
         load_data <= load_data_n;
      end
   end

   // Abort checks sit below the case and exclude byte_valid, so a byte
   // arriving on the expiry cycle is still accepted.
   always_comb begin
      state_n     = state;
      remaining_n = remaining;
      sum_n       = sum;
      addr_n      = addr;
      idle_cnt_n  = (in_frame && !byte_valid) ? idle_cnt + 1'b1 : '0;
      load_ram_n  = 1'b0;
      load_addr_n = load_addr;
      load_data_n = load_data;
      case (state)
         LD_IDLE, LD_DONE, LD_ERROR: begin
            if (byte_valid && byte_data == LOAD_HDR)
               state_n = LD_COUNT;
         end
         LD_COUNT: begin
            if (byte_valid) begin
               if (byte_data != 8'd0 && byte_data <= MAX_COUNT) begin
                  remaining_n = byte_data;
                  addr_n      = '0;
                  sum_n       = '0;
                  state_n     = LD_DATA;
               end else begin
                  state_n = LD_ERROR;
               end
            end
         end
         LD_DATA: begin
            if (byte_valid) begin
               load_ram_n  = 1'b1;
               load_addr_n = addr;
               load_data_n = byte_data;
               addr_n      = addr + 1'b1;
               sum_n       = sum + byte_data;
               remaining_n = remaining - 8'd1;
               if (remaining == 8'd1)
                  state_n = LD_CSUM;
            end
         end
         LD_CSUM: begin
            if (byte_valid)
               state_n = (byte_data == sum) ? LD_DONE : LD_ERROR;
         end
         default: state_n = LD_IDLE;
      endcase
      if (in_frame && !byte_valid && (frame_err || idle_cnt == TIMEOUT_LAST))
         state_n = LD_ERROR;
   end

endmodule

// File: tb/tb_simplecpu_uart_loader.sv
// Scoreboard bench for the UART program loader: directed frames are sent on
// uart_rx while a forked monitor checks every load_ram strobe.
module tb_simplecpu_uart_loader;
   import simplecpu_pkg::*;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       uart_rx;
   logic       load_ram;
   logic [3:0] load_addr;
   logic [7:0] load_data;
   logic       cpu_run, busy, done, error;

   int          vectors     = 0;
   int          miscompares = 0;
   logic [11:0] exp_q[$];
   logic [7:0]  ram_exp[$];
   logic [7:0]  frm[$];
   logic [7:0]  ram_model[16];
   logic [7:0]  csum;

   simplecpu_uart_loader #(
      .CLKS_PER_BIT(CPB),
      .RAM_DEPTH   (16),
      .TIMEOUT_CLKS(640)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .uart_rx  (uart_rx),
      .load_ram (load_ram),
      .load_addr(load_addr),
      .load_data(load_data),
      .cpu_run  (cpu_run),
      .busy     (busy),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
      @(negedge clk);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      uart_rx = stop_bit;
      repeat (CPB) @(negedge clk);
      uart_rx = 1'b1;
   endtask

   task automatic sendFrame();
      foreach (frm[i]) applyStimulus(frm[i], 1'b1);
   endtask

   task automatic expectStrobe(input logic [3:0] a, input logic [7:0] d);
      exp_q.push_back({a, d});
   endtask

   // Status vector order: busy, done, error, cpu_run.
   task automatic checkOutput(input string name, input logic [3:0] want);
      vectors++;
      if ({busy, done, error, cpu_run} !== want) begin
         miscompares++;
         $display("[TB] FAIL %s: got busy/done/error/cpu_run=%b, required %b",
                  name, {busy, done, error, cpu_run}, want);
      end
   endtask

   task automatic checkZero(input string name);
      vectors++;
      if ({load_ram, load_addr, load_data, busy, done, error, cpu_run} !== 17'd0) begin
         miscompares++;
         $display("[TB] FAIL %s: got outputs=%h, required 0", name,
                  {load_ram, load_addr, load_data, busy, done, error, cpu_run});
      end
   endtask

   task automatic checkQueue(input string name);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d strobes still missing, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic checkRam(input string name);
      int bad = 0;
      vectors++;
      foreach (ram_exp[i])
         if (ram_model[i] !== ram_exp[i]) begin
            bad++;
            $display("[TB] FAIL %s: ram[%0d] got %h, required %h", name, i, ram_model[i], ram_exp[i]);
         end
      if (bad != 0) miscompares++;
   endtask

   initial begin
      reset   = 1'b1;
      uart_rx = 1'b1;
      foreach (ram_model[i]) ram_model[i] = 8'h00;

      fork
         forever begin
            @(negedge clk);
            if (load_ram) begin
               logic [11:0] e;
               vectors++;
               if (exp_q.size() == 0) begin
                  miscompares++;
                  $display("[TB] FAIL strobe: got addr=%h data=%h, required no strobe",
                           load_addr, load_data);
               end else begin
                  e = exp_q.pop_front();
                  if ({load_addr, load_data} !== e) begin
                     miscompares++;
                     $display("[TB] FAIL strobe: got addr=%h data=%h, required addr=%h data=%h",
                              load_addr, load_data, e[11:8], e[7:0]);
                  end
               end
               ram_model[load_addr] = load_data;
            end
         end
      join_none

      repeat (5) @(negedge clk);
      checkZero("reset");
      reset = 1'b0;
      repeat (5) @(negedge clk);

      $display("[TB] noise bytes, glitch, then frame A5 03 51 80 90 61");
      frm = '{8'h00, 8'hFF, 8'h3C};
      sendFrame();
      checkOutput("noise_idle", 4'b0000);
      expectStrobe(4'h0, 8'h51);
      expectStrobe(4'h1, 8'h80);
      expectStrobe(4'h2, 8'h90);
      frm = '{8'hA5, 8'h03, 8'h51, 8'h80};
      sendFrame();
      @(negedge clk) uart_rx = 1'b0;
      repeat (4) @(negedge clk);
      uart_rx = 1'b1;
      repeat (40) @(negedge clk);
      frm = '{8'h90, 8'h61};
      sendFrame();
      checkOutput("frame1_done", 4'b0101);
      checkQueue("frame1_strobes");
      ram_exp = '{8'h51, 8'h80, 8'h90};
      checkRam("frame1_ram");

      $display("[TB] reload from DONE: A5 01 42 42");
      expectStrobe(4'h0, 8'h42);
      applyStimulus(8'hA5, 1'b1);
      checkOutput("reload_hdr", 4'b1000);
      frm = '{8'h01, 8'h42, 8'h42};
      sendFrame();
      checkOutput("reload_done", 4'b0101);
      checkQueue("reload_strobes");

      $display("[TB] bad checksum A5 01 10 00, then good frame");
      expectStrobe(4'h0, 8'h10);
      frm = '{8'hA5, 8'h01, 8'h10, 8'h00};
      sendFrame();
      checkOutput("bad_csum", 4'b0010);
      expectStrobe(4'h0, 8'h01);
      expectStrobe(4'h1, 8'h02);
      frm = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03};
      sendFrame();
      checkOutput("recover_done", 4'b0101);
      checkQueue("csum_strobes");

      $display("[TB] count 00 and 11");
      frm = '{8'hA5, 8'h00};
      sendFrame();
      checkOutput("count_zero", 4'b0010);
      applyStimulus(8'hA5, 1'b1);
      checkOutput("hdr_from_error", 4'b1000);
      applyStimulus(8'h11, 1'b1);
      checkOutput("count_17", 4'b0010);
      checkQueue("count_strobes");

      $display("[TB] stop bit low mid-frame");
      frm = '{8'hA5, 8'h02};
      sendFrame();
      applyStimulus(8'h33, 1'b0);
      repeat (CPB) @(negedge clk);
      checkOutput("frame_err", 4'b0010);
      checkQueue("frame_err_strobes");

      $display("[TB] timeout after two of four bytes");
      expectStrobe(4'h0, 8'h11);
      expectStrobe(4'h1, 8'h22);
      frm = '{8'hA5, 8'h04, 8'h11, 8'h22};
      sendFrame();
      repeat (600) @(negedge clk);
      checkOutput("before_timeout", 4'b1000);
      repeat (60) @(negedge clk);
      checkOutput("after_timeout", 4'b0010);
      checkQueue("timeout_strobes");

      $display("[TB] reset mid-frame");
      expectStrobe(4'h0, 8'h11);
      expectStrobe(4'h1, 8'h22);
      frm = '{8'hA5, 8'h04, 8'h11, 8'h22};
      sendFrame();
      checkOutput("pre_reset_busy", 4'b1000);
      reset = 1'b1;
      @(negedge clk);
      checkZero("mid_reset");
      repeat (3) @(negedge clk);
      reset = 1'b0;
      frm = '{8'h33, 8'h44, 8'hAA};
      sendFrame();
      checkOutput("after_reset_idle", 4'b0000);
      checkQueue("reset_strobes");

      $display("[TB] full 16-byte frame");
      frm = '{8'hA5, 8'h10};
      ram_exp.delete();
      csum = 8'h00;
      for (int i = 0; i < 16; i++) begin
         frm.push_back(8'h10 + 8'(i));
         ram_exp.push_back(8'h10 + 8'(i));
         expectStrobe(4'(i), 8'h10 + 8'(i));
         csum = csum + 8'h10 + 8'(i);
      end
      frm.push_back(csum);
      sendFrame();
      checkOutput("full_done", 4'b0101);
      checkQueue("full_strobes");
      checkRam("full_ram");

      repeat (20) @(negedge clk);
      checkQueue("final");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/simplecpu_uart_loader.md
Name: simplecpu_uart_loader

Overview:
- Host-side writer for the simplecpu program-load port: receives a framed program image over a UART RX line and drives load_ram/load_addr/load_data.
- Holds the CPU in reset while loading; releases it only after a verified image.
- Sits between the chip-level UART pin and simplecpu, replacing direct bench/pad drive of the load port.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit (minimum 4)
- RAM_DEPTH, 16, CPU RAM words; maximum accepted count
- TIMEOUT_CLKS, 640, idle clocks allowed between bytes inside a frame before abort

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- uart_rx  input  1  serial line, idle high, 8N1, LSB first, asynchronous to clk
- load_ram  output  1  one-cycle RAM write strobe to CPU
- load_addr  output  4  RAM write address
- load_data  output  8  RAM write data
- cpu_run  output  1  drives simplecpu reset input: 0 = CPU held and RAM writable, 1 = CPU runs
- busy  output  1  frame in progress
- done  output  1  last frame loaded and verified (level)
- error  output  1  last frame aborted (level)

Behaviour:
- Reset: all outputs 0; FSM to IDLE; RX to idle; checksum and address cleared. Reset mid-frame discards the frame; no further strobes.
- RX sub-block: 2-FF synchroniser on uart_rx. Falling edge starts the bit counter. Start bit is re-sampled at CLKS_PER_BIT/2; if high, it is a false start and RX returns to idle. Data bits are sampled at bit centres. The stop bit is sampled at its centre: 1 gives byte_valid for one cycle, 0 gives frame_err for one cycle and no byte.
- Frame format: 0xA5 header, COUNT, COUNT data bytes, CHECKSUM. CHECKSUM is the sum of the data bytes mod 256.
- IDLE: non-0xA5 bytes ignored. 0xA5 -> COUNT; busy=1, done=0, error=0, cpu_run=0 in the cycle after byte_valid.
- COUNT: 1..RAM_DEPTH -> DATA with addr=0 and sum=0. Values 0 or >RAM_DEPTH -> ERROR.
- DATA: each byte_valid produces a load_ram pulse in the next cycle, with load_addr=addr and load_data=byte. Then addr+1 and sum+=byte (8-bit wrap). After COUNT bytes -> CSUM.
- load_addr/load_data hold their last values between strobes.
- CSUM: received byte == sum -> DONE; otherwise -> ERROR.
- DONE: done=1, busy=0, cpu_run=1. A new 0xA5 restarts loading and drops cpu_run to 0 in the cycle after that byte.
- ERROR: error=1, busy=0, cpu_run=0. Partially written RAM is left as is. Only 0xA5 leaves ERROR (-> COUNT).
- frame_err in any state except IDLE/DONE/ERROR -> ERROR.
- Timeout: in COUNT/DATA/CSUM, a counter reloads on each byte_valid. After TIMEOUT_CLKS with no byte -> ERROR.
- Simultaneous timeout expiry and byte_valid: the byte wins.
- A header byte value inside DATA is plain data.
- At most one strobe per received byte; strobes are never back-to-back closer than one UART frame.

Decomposition:
- Shared package simplecpu_pkg holds:
  - LOAD_HDR=8'hA5
  - loader state encoding IDLE/COUNT/DATA/CSUM/DONE/ERROR
  - CPU address width 4, data width 8
  - opcode constants (shared with the CPU)
- One sub-module: simplecpu_uart_rx. Ports: clk, reset, rx, byte_valid, byte_data, frame_err; parameter CLKS_PER_BIT.

Test Plan:
- Frame A5 03 51 80 90 61 -> exactly 3 strobes: (0,51), (1,80), (2,90). Then done=1, cpu_run=1, error=0; the CPU RAM model matches.
- Frame A5 01 10 00 (checksum wrong) -> one strobe (0,10). Then error=1, cpu_run=0, done=0. A following valid frame clears error and sets done.
- Frames A5 00 and A5 11 -> no strobes, error=1 after the count byte.
- Bytes 00 FF 3C before a valid frame are ignored with no strobes. A 4-cycle low glitch on rx produces no byte. A byte with stop bit=0 mid-frame -> error=1.
- Header, count 04, then two data bytes, then silence for 640 clocks -> error=1 with only 2 strobes. Separately, reset asserted after 2 data bytes -> all outputs 0 next cycle and no further strobes; a full 16-byte frame then loads addresses 0..15 and sets done.
- After DONE, send a new frame A5 01 42 42 -> cpu_run falls the cycle after the A5 byte, one strobe (0,42), then cpu_run=1.
